// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-token symbols, receiver state and offset helper.
// Used by the transmit-side encoder and the receive-side decoder alike.
package tmds_pkg;

    typedef logic [9:0] symbol_t;

    localparam symbol_t CTRL_TOKEN_0 = 10'b1101010100;
    localparam symbol_t CTRL_TOKEN_1 = 10'b0010101011;
    localparam symbol_t CTRL_TOKEN_2 = 10'b0101010100;
    localparam symbol_t CTRL_TOKEN_3 = 10'b1010101011;

    localparam logic [3:0] OFFSET_MAX = 4'd9;

    typedef enum logic {
        SEARCH,
        LOCKED
    } state_t;

    function automatic logic [3:0] next_offset(input logic [3:0] o);
        return (o == OFFSET_MAX) ? 4'd0 : o + 4'd1;
    endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational TMDS symbol decoder: 10-bit symbol -> control token flag/value
// or 8-bit pixel data (undoes the XOR/XNOR transition-minimising stage).
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [9:0] sym,
    output logic       is_ctrl,
    output logic [1:0] ctrl,
    output logic [7:0] data
);

    logic [7:0] d_inv;

    assign d_inv = sym[9] ? ~sym[7:0] : sym[7:0];

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        is_ctrl = 1'b0;
        ctrl    = 2'b00;
        data    = '0;
        case (sym)
            CTRL_TOKEN_0: begin is_ctrl = 1'b1; ctrl = 2'b00; end
            CTRL_TOKEN_1: begin is_ctrl = 1'b1; ctrl = 2'b01; end
            CTRL_TOKEN_2: begin is_ctrl = 1'b1; ctrl = 2'b10; end
            CTRL_TOKEN_3: begin is_ctrl = 1'b1; ctrl = 2'b11; end
            default: ;
        endcase

        data[0] = d_inv[0];
        for (int i = 1; i < 8; i++) begin
            data[i] = sym[8] ? (d_inv[i] ^ d_inv[i-1]) : ~(d_inv[i] ^ d_inv[i-1]);
        end
    end

endmodule

// File: rtl/tmds_decoder.sv
// TMDS receive channel: self-aligning symbol boundary search over a 20-bit
// window of two deserialized words, lock tracking, and registered decode outputs.
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int LOCK_TOKENS   = 8,
    parameter int SEARCH_CYCLES = 64,
    parameter int LOSS_CYCLES   = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] tmds_in,
    output logic [7:0] data,
    output logic [1:0] ctrl,
    output logic       de,
    output logic       locked,
    output logic [3:0] offset
);

    localparam int TOK_W   = $clog2(LOCK_TOKENS);
    localparam int DWELL_W = $clog2(SEARCH_CYCLES);
    localparam int GAP_W   = $clog2(LOSS_CYCLES);

    localparam logic [TOK_W-1:0]   TOK_LAST   = TOK_W'(LOCK_TOKENS - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SEARCH_CYCLES - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(LOSS_CYCLES - 1);

    state_t             state;
    logic [9:0]         r0, r1;
    logic [19:0]        window;
    logic [4:0]         sel;
    symbol_t            word;
    logic [TOK_W-1:0]   tok_cnt;
    logic [DWELL_W-1:0] dwell;
    logic [GAP_W-1:0]   gap;

    logic               dec_is_ctrl;
    logic [1:0]         dec_ctrl;
    logic [7:0]         dec_data;

    // r0 is the newer word, so higher offsets pull their top bits from it.
    assign window = {r0, r1};
    assign sel    = {1'b0, offset};
    assign word   = window[sel +: 10];

    tmds_symbol_decode u_decode (
        .sym     (word),
        .is_ctrl (dec_is_ctrl),
        .ctrl    (dec_ctrl),
        .data    (dec_data)
    );

    // Each counter is cleared by the same branch that tests its terminal value,
    // so an increment can never run past it and wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= SEARCH;
            r0      <= '0;
            r1      <= '0;
            offset  <= '0;
            tok_cnt <= '0;
            dwell   <= '0;
            gap     <= '0;
            locked  <= 1'b0;
            de      <= 1'b0;
            ctrl    <= 2'b00;
            data    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r0 <= tmds_in;
            r1 <= r0;
            case (state)
                SEARCH: begin
                    de   <= 1'b0;
                    ctrl <= 2'b00;
                    data <= '0;
                    if (dec_is_ctrl && tok_cnt == TOK_LAST) begin
                        state   <= LOCKED;
                        locked  <= 1'b1;
                        tok_cnt <= '0;
                        dwell   <= '0;
                        gap     <= '0;
                    end else if (dwell == DWELL_LAST) begin
                        offset  <= next_offset(offset);
                        dwell   <= '0;
                        tok_cnt <= '0;
                    end else begin
                        dwell   <= dwell + DWELL_W'(1);
                        tok_cnt <= dec_is_ctrl ? tok_cnt + TOK_W'(1) : '0;
                    end
                end
                LOCKED: begin
                    if (dec_is_ctrl) begin
                        gap  <= '0;
                        de   <= 1'b0;
                        ctrl <= dec_ctrl;
                        data <= '0;
                    end else if (gap == GAP_LAST) begin
                        state   <= SEARCH;
                        locked  <= 1'b0;
                        offset  <= next_offset(offset);
                        gap     <= '0;
                        dwell   <= '0;
                        tok_cnt <= '0;
                        de      <= 1'b0;
                        ctrl    <= 2'b00;
                        data    <= '0;
                    end else begin
                        gap  <= gap + GAP_W'(1);
                        de   <= 1'b1;
                        data <= dec_data;
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end

endmodule

// File: tb/tb_tmds_decoder.sv
// Scoreboard bench for tmds_decoder: directed symbol streams with hand-decoded
// expectations, a de-driven monitor, and direct checks of lock/offset timing.
module tb_tmds_decoder;
    import tmds_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] tmds_in;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       de;
    logic       locked;
    logic [3:0] offset;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] ctrl;
    } exp_t;

    exp_t       exp_q[$];
    int         errors = 0;
    int         checks = 0;
    logic [9:0] prev_sym;
    int         skew;

    tmds_decoder dut (
        .clk     (clk),
        .rst     (rst),
        .tmds_in (tmds_in),
        .data    (data),
        .ctrl    (ctrl),
        .de      (de),
        .locked  (locked),
        .offset  (offset)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present one symbol on the serial stream, shifted by skew bits across word boundaries.
    task automatic send(input logic [9:0] sym, input bit expect_de,
                        input logic [7:0] d, input logic [1:0] c);
        logic [19:0] cat;
        cat      = {sym, prev_sym} >> (10 - skew);
        tmds_in  = cat[9:0];
        prev_sym = sym;
        if (expect_de) exp_q.push_back({d, c});
        @(negedge clk);
    endtask

    task automatic send_tok(input logic [9:0] sym, input int n);
        for (int i = 0; i < n; i++) send(sym, 1'b0, 8'h00, 2'b00);
    endtask

    task automatic do_reset(input int n, input logic [9:0] hold);
        rst      = 1'b1;
        tmds_in  = hold;
        prev_sym = '0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_data"},   data,   8'h00);
        check({tag, "_ctrl"},   ctrl,   2'b00);
        check({tag, "_de"},     de,     1'b0);
        check({tag, "_locked"}, locked, 1'b0);
        check({tag, "_offset"}, offset, 4'd0);
    endtask

    // Monitor: every de=1 cycle must match the oldest queued expectation.
    always @(negedge clk) begin
        if (de === 1'b1) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_de: got data=%0h ctrl=%0b expected no output", data, ctrl);
            end else begin
                e = exp_q.pop_front();
                check("de_data", data, e.data);
                check("de_ctrl", ctrl, e.ctrl);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] seq [18];

        rst      = 1'b1;
        tmds_in  = '0;
        skew     = 0;
        prev_sym = '0;
        @(negedge clk);
        do_reset(3, 10'h000);
        check_idle("reset");

        // Aligned CTRL_TOKEN_0 stream: the 8th token is judged two cycles after it is sent.
        send_tok(CTRL_TOKEN_0, 9);
        check("lock_early", locked, 1'b0);
        send_tok(CTRL_TOKEN_0, 1);
        check("lock_at_8", locked, 1'b1);
        check("lock_offset", offset, 4'd0);
        send_tok(CTRL_TOKEN_0, 1);
        check("lock_de", de, 1'b0);
        check("lock_ctrl", ctrl, 2'b00);

        // Data words while locked, hand-decoded.
        send(10'h100, 1'b1, 8'h00, 2'b00);
        send(10'h1FF, 1'b1, 8'h01, 2'b00);
        send(10'h3FF, 1'b1, 8'h00, 2'b00);
        send(10'h000, 1'b1, 8'hFE, 2'b00);
        send(10'h155, 1'b1, 8'hFF, 2'b00);
        send(10'h2AA, 1'b1, 8'h01, 2'b00);
        send_tok(CTRL_TOKEN_0, 3);
        check("data_drained", exp_q.size(), 0);

        // 7 tokens, one data word, then a fresh run: only the second run may lock.
        do_reset(2, 10'h000);
        for (int i = 0; i < 18; i++) seq[i] = (i == 7) ? 10'h100 : CTRL_TOKEN_0;
        for (int i = 0; i < 18; i++) begin
            send(seq[i], 1'b0, 8'h00, 2'b00);
            if (i == 10) check("broken_run_no_lock", locked, 1'b0);
            if (i == 16) check("second_run_early", locked, 1'b0);
            if (i == 17) check("second_run_lock", locked, 1'b1);
        end

        // Loss of lock: the 4096th consecutive data word drops lock and advances offset.
        for (int i = 0; i < 4096; i++) send(10'h100, (i < 4095), 8'h00, 2'b00);
        send(10'h100, 1'b0, 8'h00, 2'b00);
        check("loss_hold", locked, 1'b1);
        send(10'h100, 1'b0, 8'h00, 2'b00);
        check("loss_locked", locked, 1'b0);
        check("loss_offset", offset, 4'd1);
        check("loss_de", de, 1'b0);
        check("loss_drained", exp_q.size(), 0);

        // CTRL_TOKEN_2 stream skewed by 3 bits: offset walks 0..3, 64 cycles each.
        do_reset(2, 10'h000);
        skew = 3;
        for (int i = 0; i < 206; i++) begin
            send(CTRL_TOKEN_2, 1'b0, 8'h00, 2'b00);
            if (i == 62)  check("skew_off0", offset, 4'd0);
            if (i == 63)  check("skew_off1", offset, 4'd1);
            if (i == 127) check("skew_off2", offset, 4'd2);
            if (i == 191) check("skew_off3", offset, 4'd3);
            if (i == 198) check("skew_lock_early", locked, 1'b0);
            if (i == 199) check("skew_lock", locked, 1'b1);
            if (i == 200) check("skew_ctrl", ctrl, 2'b10);
            if (i == 200) check("skew_de", de, 1'b0);
        end
        // ctrl keeps its last token value across a data word.
        send(10'h100, 1'b1, 8'h00, 2'b10);
        send_tok(CTRL_TOKEN_2, 3);
        check("skew_offset_frozen", offset, 4'd3);

        // Reset mid-lock: everything returns to reset state, then a fresh run relocks.
        do_reset(1, CTRL_TOKEN_2);
        check_idle("midreset");
        skew = 0;
        send_tok(CTRL_TOKEN_0, 9);
        check("relock_early", locked, 1'b0);
        send_tok(CTRL_TOKEN_0, 1);
        check("relock", locked, 1'b1);
        check("relock_offset", offset, 4'd0);

        check("final_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
